// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, FSM states and flag bit positions for the ALU arbiter
package alu_pkg;
  localparam logic [2:0] FUN_ADD = 3'b000;
  localparam logic [2:0] FUN_SUB = 3'b001;
  localparam logic [2:0] FUN_AND = 3'b010;
  localparam logic [2:0] FUN_OR  = 3'b011;
  localparam logic [2:0] FUN_NOR = 3'b100;
  localparam logic [2:0] FUN_LSL = 3'b101;
  localparam logic [2:0] FUN_LSR = 3'b110;
  localparam logic [2:0] FUN_ASR = 3'b111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;
endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - two-requester operation/result handshake bundle
interface alu_arbiter_if;
  logic        r0_valid;
  logic        r0_ready;
  logic [15:0] r0_a;
  logic [15:0] r0_b;
  logic [2:0]  r0_fun;
  logic        r0_rvalid;
  logic        r0_rready;
  logic [16:0] r0_r;
  logic [3:0]  r0_flags;

  logic        r1_valid;
  logic        r1_ready;
  logic [15:0] r1_a;
  logic [15:0] r1_b;
  logic [2:0]  r1_fun;
  logic        r1_rvalid;
  logic        r1_rready;
  logic [16:0] r1_r;
  logic [3:0]  r1_flags;

  modport master (
    output r0_valid, r0_a, r0_b, r0_fun, r0_rready,
    output r1_valid, r1_a, r1_b, r1_fun, r1_rready,
    input  r0_ready, r0_rvalid, r0_r, r0_flags,
    input  r1_ready, r1_rvalid, r1_r, r1_flags
  );

  modport slave (
    input  r0_valid, r0_a, r0_b, r0_fun, r0_rready,
    input  r1_valid, r1_a, r1_b, r1_fun, r1_rready,
    output r0_ready, r0_rvalid, r0_r, r0_flags,
    output r1_ready, r1_rvalid, r1_r, r1_flags
  );
endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way grant from valids; ties go to whoever was not served last
module rr_arb2 #(
  parameter int FIXED_PRIO = 0
) (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ((FIXED_PRIO != 0) || last) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one external ALU between two requesters, one op at a time
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave req,
  output logic [15:0]  alu_a,
  output logic [15:0]  alu_b,
  output logic [2:0]   alu_fun,
  input  logic [16:0]  alu_r,
  input  logic         alu_n,
  input  logic         alu_z,
  input  logic         alu_c,
  input  logic         alu_v,
  output logic         busy
);
  state_t      state;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [2:0]  op_fun;
  logic        owner;
  logic        last;
  logic [16:0] res_r;
  logic [3:0]  res_flags;
  logic [1:0]  grant;
  logic        resp_taken;

  rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .valid ({req.r1_valid, req.r0_valid}),
    .last  (last),
    .grant (grant)
  );

  assign resp_taken = owner ? req.r1_rready : req.r0_rready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_a      <= '0;
      op_b      <= '0;
      op_fun    <= '0;
      owner     <= 1'b0;
      last      <= 1'b1;
      res_r     <= '0;
      res_flags <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant != 2'b00) begin
            op_a   <= grant[1] ? req.r1_a   : req.r0_a;
            op_b   <= grant[1] ? req.r1_b   : req.r0_b;
            op_fun <= grant[1] ? req.r1_fun : req.r0_fun;
            owner  <= grant[1];
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_r             <= alu_r;
          res_flags[FLAG_N] <= alu_n;
          res_flags[FLAG_Z] <= alu_z;
          res_flags[FLAG_C] <= alu_c;
          res_flags[FLAG_V] <= alu_v;
          state             <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_taken) begin
            last  <= owner;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ready is gated by rst_n so it stays low while reset is held with valids up
  assign req.r0_ready  = rst_n && (state == ST_IDLE) && grant[0];
  assign req.r1_ready  = rst_n && (state == ST_IDLE) && grant[1];
  assign req.r0_rvalid = (state == ST_RESP) && !owner;
  assign req.r1_rvalid = (state == ST_RESP) && owner;
  assign req.r0_r      = res_r;
  assign req.r1_r      = res_r;
  assign req.r0_flags  = res_flags;
  assign req.r1_flags  = res_flags;

  assign alu_a   = op_a;
  assign alu_b   = op_b;
  assign alu_fun = op_fun;
  assign busy    = (state != ST_IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a behavioural ALU and model
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_arbiter_if ifc0 ();
  alu_arbiter_if ifc1 ();

  function automatic logic [20:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] f);
    logic [16:0] r;
    logic        v;
    v = 1'b0;
    case (f)
      FUN_ADD: begin r = {1'b0, a} + {1'b0, b}; v = (a[15] == b[15]) && (r[15] != a[15]); end
      FUN_SUB: begin r = {1'b0, a} - {1'b0, b}; v = (a[15] != b[15]) && (r[15] != a[15]); end
      FUN_AND: r = {1'b0, a & b};
      FUN_OR:  r = {1'b0, a | b};
      FUN_NOR: r = {1'b0, ~(a | b)};
      FUN_LSL: r = {1'b0, a} << b[3:0];
      FUN_LSR: r = {1'b0, a >> b[3:0]};
      default: r = {1'b0, 16'($signed(a) >>> b[3:0])};
    endcase
    return {r[15], (r[15:0] == 16'h0), r[16], v, r};
  endfunction

  logic [15:0] a0_a, a0_b, a1_a, a1_b;
  logic [2:0]  a0_fun, a1_fun;
  logic [20:0] a0_o, a1_o;
  logic        busy0, busy1;

  assign a0_o = alu_ref(a0_a, a0_b, a0_fun);
  assign a1_o = alu_ref(a1_a, a1_b, a1_fun);

  // the fixed-priority instance sees exactly the same requester stimulus
  assign ifc1.r0_valid  = ifc0.r0_valid;
  assign ifc1.r0_a      = ifc0.r0_a;
  assign ifc1.r0_b      = ifc0.r0_b;
  assign ifc1.r0_fun    = ifc0.r0_fun;
  assign ifc1.r0_rready = ifc0.r0_rready;
  assign ifc1.r1_valid  = ifc0.r1_valid;
  assign ifc1.r1_a      = ifc0.r1_a;
  assign ifc1.r1_b      = ifc0.r1_b;
  assign ifc1.r1_fun    = ifc0.r1_fun;
  assign ifc1.r1_rready = ifc0.r1_rready;

  alu_arbiter #(.FIXED_PRIO(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(ifc0.slave),
    .alu_a(a0_a), .alu_b(a0_b), .alu_fun(a0_fun), .alu_r(a0_o[16:0]),
    .alu_n(a0_o[20]), .alu_z(a0_o[19]), .alu_c(a0_o[18]), .alu_v(a0_o[17]),
    .busy(busy0)
  );

  alu_arbiter #(.FIXED_PRIO(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(ifc1.slave),
    .alu_a(a1_a), .alu_b(a1_b), .alu_fun(a1_fun), .alu_r(a1_o[16:0]),
    .alu_n(a1_o[20]), .alu_z(a1_o[19]), .alu_c(a1_o[18]), .alu_v(a1_o[17]),
    .busy(busy1)
  );

  task automatic idle_inputs();
    ifc0.r0_valid = 1'b0; ifc0.r1_valid = 1'b0;
    ifc0.r0_rready = 1'b0; ifc0.r1_rready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n;
    idle_inputs();
    ifc0.r0_rready = 1'b1; ifc0.r1_rready = 1'b1;
    n = 0;
    while ((busy0 || busy1) && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy0 || busy1) begin
      errors++; $display("FAIL drain_timeout busy0=%b busy1=%b required=0", busy0, busy1);
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ifc0.r0_valid = 1'b1; ifc0.r1_valid = 1'b1;
    ifc0.r0_rready = 1'b1; ifc0.r1_rready = 1'b1;
    ifc0.r0_a = 16'($urandom); ifc0.r0_b = 16'($urandom); ifc0.r0_fun = 3'($urandom);
    ifc0.r1_a = 16'($urandom); ifc0.r1_b = 16'($urandom); ifc0.r1_fun = 3'($urandom);
    @(negedge clk);
    checks++;
    if ({ifc0.r0_ready, ifc0.r1_ready, ifc1.r0_ready, ifc1.r1_ready} !== 4'b0) begin
      errors++; $display("FAIL reset_ready got=%b required=0000",
                         {ifc0.r0_ready, ifc0.r1_ready, ifc1.r0_ready, ifc1.r1_ready});
    end
    checks++;
    if ({ifc0.r0_rvalid, ifc0.r1_rvalid, busy0} !== 3'b0) begin
      errors++; $display("FAIL reset_rvalid_busy got=%b required=000",
                         {ifc0.r0_rvalid, ifc0.r1_rvalid, busy0});
    end
    checks++;
    if ({ifc0.r0_r, ifc0.r0_flags, ifc0.r1_r, ifc0.r1_flags} !== 42'h0) begin
      errors++; $display("FAIL reset_result got=%h required=0",
                         {ifc0.r0_r, ifc0.r0_flags, ifc0.r1_r, ifc0.r1_flags});
    end
    checks++;
    if ({a0_a, a0_b, a0_fun} !== 35'h0) begin
      errors++; $display("FAIL reset_alu got=%h required=0", {a0_a, a0_b, a0_fun});
    end
    idle_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    ifc0.r0_valid = 1'b1; ifc0.r0_a = 16'h7FFF; ifc0.r0_b = 16'h0001; ifc0.r0_fun = FUN_ADD;
    #1;
    checks++;
    if (ifc0.r0_ready !== 1'b1) begin
      errors++; $display("FAIL single_ready got=%b required=1", ifc0.r0_ready);
    end
    @(negedge clk);
    ifc0.r0_valid = 1'b0; ifc0.r0_a = 16'h1234;
    #1;
    checks++;
    if ({busy0, ifc0.r0_rvalid, a0_a} !== {1'b1, 1'b0, 16'h7FFF}) begin
      errors++; $display("FAIL single_exec busy,rvalid,alu_a got=%h required=%h",
                         {busy0, ifc0.r0_rvalid, a0_a}, {1'b1, 1'b0, 16'h7FFF});
    end
    @(negedge clk);
    checks++;
    if ({ifc0.r0_rvalid, ifc0.r1_rvalid, ifc0.r0_r, ifc0.r0_flags} !==
        {1'b1, 1'b0, 17'h08000, 4'b1001}) begin
      errors++; $display("FAIL single_resp got=%h required=%h",
                         {ifc0.r0_rvalid, ifc0.r1_rvalid, ifc0.r0_r, ifc0.r0_flags},
                         {1'b1, 1'b0, 17'h08000, 4'b1001});
    end
    ifc0.r1_rready = 1'b1;
    @(negedge clk);
    checks++;
    if (ifc0.r0_rvalid !== 1'b1) begin
      errors++; $display("FAIL single_nonowner_rready rvalid got=%b required=1", ifc0.r0_rvalid);
    end
    ifc0.r1_rready = 1'b0; ifc0.r0_rready = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy0, ifc0.r0_rvalid} !== 2'b00) begin
      errors++; $display("FAIL single_done got=%b required=00", {busy0, ifc0.r0_rvalid});
    end
    idle_inputs();
  endtask

  task automatic test_tie();
    do_reset();
    ifc0.r0_valid = 1'b1; ifc0.r0_a = 16'd5; ifc0.r0_b = 16'd5; ifc0.r0_fun = FUN_SUB;
    ifc0.r1_valid = 1'b1; ifc0.r1_a = 16'h00F0; ifc0.r1_b = 16'h0F00; ifc0.r1_fun = FUN_OR;
    #1;
    checks++;
    if ({ifc0.r1_ready, ifc0.r0_ready} !== 2'b01) begin
      errors++; $display("FAIL tie_first_grant got=%b required=01", {ifc0.r1_ready, ifc0.r0_ready});
    end
    @(negedge clk);
    ifc0.r0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({ifc0.r0_rvalid, ifc0.r0_r, ifc0.r0_flags} !== {1'b1, 17'h0, 4'b0100}) begin
      errors++; $display("FAIL tie_r0_result got=%h required=%h",
                         {ifc0.r0_rvalid, ifc0.r0_r, ifc0.r0_flags}, {1'b1, 17'h0, 4'b0100});
    end
    ifc0.r0_rready = 1'b1;
    @(negedge clk);
    ifc0.r0_rready = 1'b0;
    #1;
    checks++;
    if (ifc0.r1_ready !== 1'b1) begin
      errors++; $display("FAIL tie_second_grant got=%b required=1", ifc0.r1_ready);
    end
    @(negedge clk);
    ifc0.r1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({ifc0.r1_rvalid, ifc0.r0_rvalid, ifc0.r1_r, ifc0.r1_flags} !==
        {1'b1, 1'b0, 17'h00FF0, 4'b0000}) begin
      errors++; $display("FAIL tie_r1_result got=%h required=%h",
                         {ifc0.r1_rvalid, ifc0.r0_rvalid, ifc0.r1_r, ifc0.r1_flags},
                         {1'b1, 1'b0, 17'h00FF0, 4'b0000});
    end
    drain();
  endtask

  task automatic test_alternate();
    int q0[$];
    int q1[$];
    int n;
    do_reset();
    ifc0.r0_valid = 1'b1; ifc0.r1_valid = 1'b1;
    ifc0.r0_rready = 1'b1; ifc0.r1_rready = 1'b1;
    n = 0;
    while ((q0.size() < 4 || q1.size() < 4) && n < 40) begin
      ifc0.r0_a = 16'($urandom); ifc0.r0_fun = 3'($urandom);
      ifc0.r1_a = 16'($urandom); ifc0.r1_fun = 3'($urandom);
      #1;
      if (ifc0.r0_ready) q0.push_back(0);
      if (ifc0.r1_ready) q0.push_back(1);
      if (ifc1.r0_ready) q1.push_back(0);
      if (ifc1.r1_ready) q1.push_back(1);
      @(negedge clk);
      n++;
    end
    checks++;
    if (q0.size() < 4 || q1.size() < 4) begin
      errors++; $display("FAIL alternate_timeout grants rr=%0d fixed=%0d required>=4",
                         q0.size(), q1.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (q0[i] !== (i % 2)) begin
          errors++; $display("FAIL alternate_rr op%0d got=%0d required=%0d", i, q0[i], i % 2);
        end
        checks++;
        if (q1[i] !== 0) begin
          errors++; $display("FAIL alternate_fixed op%0d got=%0d required=0", i, q1[i]);
        end
      end
    end
    drain();
  endtask

  task automatic test_hold();
    do_reset();
    ifc0.r1_valid = 1'b1; ifc0.r1_a = 16'h8000; ifc0.r1_b = 16'd4; ifc0.r1_fun = FUN_ASR;
    @(negedge clk);
    ifc0.r1_valid = 1'b0;
    ifc0.r0_valid = 1'b1; ifc0.r0_a = 16'h0003; ifc0.r0_b = 16'h0004; ifc0.r0_fun = FUN_AND;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      ifc0.r1_a = 16'($urandom);
      ifc0.r0_rready = 1'($urandom);
      #1;
      checks++;
      if ({ifc0.r1_rvalid, ifc0.r1_r, ifc0.r1_flags, ifc0.r0_ready, ifc0.r0_rvalid} !==
          {1'b1, 17'h0F800, 4'b1000, 1'b0, 1'b0}) begin
        errors++; $display("FAIL hold_cycle%0d got=%h required=%h", i,
                           {ifc0.r1_rvalid, ifc0.r1_r, ifc0.r1_flags, ifc0.r0_ready, ifc0.r0_rvalid},
                           {1'b1, 17'h0F800, 4'b1000, 1'b0, 1'b0});
      end
      @(negedge clk);
    end
    ifc0.r0_rready = 1'b0;
    ifc0.r1_rready = 1'b1;
    @(negedge clk);
    ifc0.r1_rready = 1'b0;
    #1;
    checks++;
    if ({ifc0.r1_rvalid, ifc0.r0_ready} !== 2'b01) begin
      errors++; $display("FAIL hold_release got=%b required=01", {ifc0.r1_rvalid, ifc0.r0_ready});
    end
    @(negedge clk);
    drain();
  endtask

  task automatic test_reset_mid();
    do_reset();
    ifc0.r0_valid = 1'b1; ifc0.r0_a = 16'($urandom); ifc0.r0_b = 16'($urandom | 1);
    ifc0.r0_fun = FUN_OR;
    @(negedge clk);
    ifc0.r0_valid = 1'b0;
    checks++;
    if (busy0 !== 1'b1) begin
      errors++; $display("FAIL midreset_exec busy got=%b required=1", busy0);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy0, ifc0.r0_rvalid, ifc0.r1_rvalid, ifc0.r0_ready, ifc0.r1_ready,
         ifc0.r0_r, ifc0.r0_flags, a0_a, a0_b, a0_fun} !== 60'h0) begin
      errors++; $display("FAIL midreset_outputs got=%h required=0",
                         {busy0, ifc0.r0_rvalid, ifc0.r1_rvalid, ifc0.r0_ready, ifc0.r1_ready,
                          ifc0.r0_r, ifc0.r0_flags, a0_a, a0_b, a0_fun});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({ifc0.r0_rvalid, busy0} !== 2'b00) begin
      errors++; $display("FAIL midreset_no_resp got=%b required=00", {ifc0.r0_rvalid, busy0});
    end
    ifc0.r0_valid = 1'b1; ifc0.r0_a = 16'd1; ifc0.r0_b = 16'd2; ifc0.r0_fun = FUN_ADD;
    ifc0.r1_valid = 1'b1; ifc0.r1_a = 16'd9; ifc0.r1_b = 16'd9; ifc0.r1_fun = FUN_AND;
    #1;
    checks++;
    if ({ifc0.r1_ready, ifc0.r0_ready} !== 2'b01) begin
      errors++; $display("FAIL midreset_tie got=%b required=01", {ifc0.r1_ready, ifc0.r0_ready});
    end
    @(negedge clk);
    ifc0.r0_valid = 1'b0; ifc0.r1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({ifc0.r0_rvalid, ifc0.r0_r} !== {1'b1, 17'd3}) begin
      errors++; $display("FAIL midreset_next_op got=%h required=%h",
                         {ifc0.r0_rvalid, ifc0.r0_r}, {1'b1, 17'd3});
    end
    drain();
  endtask

  task automatic test_random();
    logic        pend;
    int          age;
    int          own;
    int          last_served;
    int          winner;
    logic [20:0] expv;
    logic [1:0]  exp_ready, exp_rvalid;
    logic [1:0]  rdy;
    do_reset();
    pend = 1'b0; age = 0; own = 0; last_served = 1; expv = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      ifc0.r0_valid  = ($urandom_range(0, 9) < 6);
      ifc0.r1_valid  = ($urandom_range(0, 9) < 6);
      ifc0.r0_rready = 1'($urandom);
      ifc0.r1_rready = 1'($urandom);
      ifc0.r0_a = 16'($urandom); ifc0.r0_b = 16'($urandom); ifc0.r0_fun = 3'($urandom);
      ifc0.r1_a = 16'($urandom); ifc0.r1_b = 16'($urandom); ifc0.r1_fun = 3'($urandom);
      #1;
      winner = -1;
      if (ifc0.r0_valid && ifc0.r1_valid) winner = (last_served == 1) ? 0 : 1;
      else if (ifc0.r0_valid)             winner = 0;
      else if (ifc0.r1_valid)             winner = 1;
      exp_ready  = 2'b00;
      exp_rvalid = 2'b00;
      if (!pend && winner >= 0) exp_ready[winner] = 1'b1;
      if (pend && age >= 1)     exp_rvalid[own] = 1'b1;
      checks++;
      if ({ifc0.r1_ready, ifc0.r0_ready, ifc0.r1_rvalid, ifc0.r0_rvalid, busy0} !==
          {exp_ready, exp_rvalid, pend}) begin
        errors++; $display("FAIL random_ctrl cyc%0d got=%b required=%b", cyc,
                           {ifc0.r1_ready, ifc0.r0_ready, ifc0.r1_rvalid, ifc0.r0_rvalid, busy0},
                           {exp_ready, exp_rvalid, pend});
      end
      if (pend && age >= 1) begin
        checks++;
        if ({ifc0.r0_flags, ifc0.r0_r} !== expv || {ifc0.r1_flags, ifc0.r1_r} !== expv) begin
          errors++; $display("FAIL random_result cyc%0d got=%h required=%h", cyc,
                             {ifc0.r0_flags, ifc0.r0_r}, expv);
        end
      end
      rdy = {ifc0.r1_rready, ifc0.r0_rready};
      if (!pend) begin
        if (winner >= 0) begin
          pend = 1'b1; age = 0; own = winner;
          expv = (winner == 0) ? alu_ref(ifc0.r0_a, ifc0.r0_b, ifc0.r0_fun)
                               : alu_ref(ifc0.r1_a, ifc0.r1_b, ifc0.r1_fun);
        end
      end else if (age == 0) begin
        age = 1;
      end else if (rdy[own]) begin
        pend = 1'b0; last_served = own;
      end
      @(negedge clk);
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    ifc0.r0_a = '0; ifc0.r0_b = '0; ifc0.r0_fun = '0;
    ifc0.r1_a = '0; ifc0.r1_b = '0; ifc0.r1_fun = '0;
    test_reset();
    test_single();
    test_tie();
    test_alternate();
    test_hold();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 0, 0 = round-robin between requesters, 1 = requester 0 always wins a tie.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 rK_valid  in  1  requester K (K=0,1) presents an operation.
REQ-005 rK_ready  out  1  arbiter accepts requester K's operation this cycle.
REQ-006 rK_a, rK_b  in  16 each  operands from requester K.
REQ-007 rK_fun  in  3  ALU op code: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOR, 101 LSL, 110 LSR, 111 ASR.
REQ-008 rK_rvalid  out  1  result for requester K is available.
REQ-009 rK_rready  in  1  requester K consumes the result.
REQ-010 rK_r  out  17  registered 17-bit ALU result for requester K.
REQ-011 rK_flags  out  4  registered flags {N,Z,C,V} for requester K.
REQ-012 alu_a, alu_b  out  16 each  operands driven to the shared ALU.
REQ-013 alu_fun  out  3  op code driven to the shared ALU.
REQ-014 alu_r  in  17  combinational ALU result; alu_n, alu_z, alu_c, alu_v  in  1 each  ALU flags.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 FSM states: IDLE, EXEC, RESP; only path IDLE->EXEC->RESP->IDLE.
REQ-017 IDLE: winner = only valid requester; if both valid, winner = requester not served last (FIXED_PRIO=1: requester 0).
REQ-018 IDLE: rK_ready = 1 only for the winner, 0 otherwise; no valid -> both ready 0, remain IDLE.
REQ-019 Acceptance (valid & ready): latch a, b, fun and owner ID into op registers; next state EXEC.
REQ-020 alu_a/alu_b/alu_fun always driven from op registers; operands sampled only at acceptance, later input changes ignored.
REQ-021 EXEC: one cycle; capture alu_r and {alu_n,alu_z,alu_c,alu_v} into result registers at end of cycle; next state RESP.
REQ-022 RESP: owner's rK_rvalid = 1, other rvalid = 0; rK_r/rK_flags hold constant until handshake.
REQ-023 RESP with owner rK_rready = 1: return to IDLE; last-served pointer := owner.
REQ-024 Latency: accept at edge t -> rvalid high from cycle t+2; minimum 3 cycles per operation; no acceptance in RESP or EXEC.
REQ-025 rK_r and rK_flags are the shared result registers presented to both ports; only rvalid distinguishes owner.
REQ-026 rready from non-owner, or in IDLE/EXEC, has no effect.
REQ-027 Valid deasserted by requester before acceptance: no operation, no pointer change.
REQ-028 Requester serviced again immediately: permitted if the other requester is not valid in IDLE.

Reset
REQ-029 rst_n low: state IDLE, op/result registers 0, last-served pointer = 1 (requester 0 wins first tie).
REQ-030 Outputs during/after reset: all ready 0, rvalid 0, busy 0, rK_r 0, rK_flags 0, alu_* 0.
REQ-031 Reset mid-operation: in-flight operation discarded, no response issued.

Structure
REQ-032 Shared package alu_pkg: fun code constants, FSM state enum, flag bit indices (N=3, Z=2, C=1, V=0).
REQ-033 Sub-module rr_arb2: 2-way round-robin grant from valids, last-served pointer and FIXED_PRIO.
REQ-034 ALU instantiated outside this block; arbiter connects only through alu_* ports.

Verification
REQ-035 r0 only: ADD a=0x7FFF b=0x0001 -> r0_rvalid at t+2, r=0x08000, flags N=1 Z=0 C=0 V=1.
REQ-036 Both valid from reset: r0 SUB 5-5, r1 OR 0x00F0|0x0F00 -> r0 served first (r=0, Z=1), then r1 (r=0x00FF0).
REQ-037 Both held valid continuously -> grants alternate 0,1,0,1 for 4 ops; FIXED_PRIO=1 -> r0 four times.
REQ-038 r1 ASR 0x8000 by 4, r1_rready low 5 cycles -> r1_rvalid and r1_r=0x0F800 held stable, r0 ignored until handshake.
REQ-039 rst_n pulsed low during EXEC -> no rvalid, all outputs 0, next op accepted normally with r0 winning tie.
